multdiv_iter: RTL and testbench

//  Iterative signed 32-bit multiply/divide unit beside the ALU in the execute stage.
//  It consumes the 32-bit carry-lookahead add/sub block: one add or subtract per iteration.

---
 rtl/multdiv_pkg.sv | 10 +
 rtl/multdiv_if.sv | 21 ++
 rtl/booth_recode4.sv | 18 +
 rtl/cla_addsub32.sv | 41 ++++
 rtl/multdiv_iter.sv | 146 ++++++++++++++
 tb/tb_multdiv_iter.sv | 171 +++++++++++++++++
 6 files changed

// File: rtl/multdiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package multdiv_pkg;
    localparam int WIDTH      = 32;
    localparam int MULT_ITERS = 16;
    localparam int DIV_ITERS  = 32;

    typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_e;

    typedef enum logic [2:0] {ZERO, ADD_M, ADD_2M, SUB_M, SUB_2M} booth_op_e;
endpackage

// File: rtl/multdiv_if.sv
// Request/response bundle between the execute stage and the multiply/divide unit.
interface multdiv_if;
    logic                           ctrl_MULT;
    logic                           ctrl_DIV;
    logic [multdiv_pkg::WIDTH-1:0]  data_operandA;
    logic [multdiv_pkg::WIDTH-1:0]  data_operandB;
    logic [multdiv_pkg::WIDTH-1:0]  data_result;
    logic                           data_exception;
    logic                           data_resultRDY;
    logic                           busy;

    modport master (
        output ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
        input  data_result, data_exception, data_resultRDY, busy
    );

    modport slave (
        input  ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
        output data_result, data_exception, data_resultRDY, busy
    );
endinterface

// File: rtl/booth_recode4.sv
// Radix-4 Booth recoder: three overlapping multiplier bits to an add/subtract selection.
module booth_recode4
    import multdiv_pkg::*;
(
    input  logic [2:0] bits,
    output booth_op_e  op
);
    always_comb begin
        op = ZERO;
        case (bits)
            3'b001, 3'b010: op = ADD_M;
            3'b011:         op = ADD_2M;
            3'b100:         op = SUB_2M;
            3'b101, 3'b110: op = SUB_M;
            default:        op = ZERO;
        endcase
    end
endmodule

// File: rtl/cla_addsub32.sv
// 32-bit carry-lookahead adder/subtractor: sum = a + (sub ? ~b + 1 : b).
module cla_addsub32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        sub,
    output logic [31:0] sum,
    output logic        cout
);
    logic [31:0] bx, g, p;
    logic [7:0]  grp_g, grp_p;
    logic [32:0] c;

    assign bx = b ^ {32{sub}};
    assign g  = a & bx;
    assign p  = a ^ bx;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_group
            assign grp_g[gi] = g[4*gi+3]
                             | (p[4*gi+3] & g[4*gi+2])
                             | (p[4*gi+3] & p[4*gi+2] & g[4*gi+1])
                             | (p[4*gi+3] & p[4*gi+2] & p[4*gi+1] & g[4*gi]);
            assign grp_p[gi] = &p[4*gi+3:4*gi];
        end
    endgenerate

    // Group carries skip across each nibble; inner carries only look back into their own group.
    always_comb begin
        c    = '0;
        c[0] = sub;
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 3; j++) begin
                c[4*i+j+1] = g[4*i+j] | (p[4*i+j] & c[4*i+j]);
            end
            c[4*i+4] = grp_g[i] | (grp_p[i] & c[4*i]);
        end
    end

    assign sum  = p ^ c[31:0];
    assign cout = c[32];
endmodule

// File: rtl/multdiv_iter.sv
// Iterative signed 32-bit multiply (radix-4 Booth) and divide (restoring on magnitudes).
module multdiv_iter
    import multdiv_pkg::*;
#(
    parameter int MULT_LAT = MULT_ITERS + 1,
    parameter int DIV_LAT  = DIV_ITERS + 1
) (
    input  logic     clock,
    input  logic     reset_n,
    multdiv_if.slave bus
);
    localparam logic [4:0] MULT_LAST = 5'(MULT_LAT - 2);
    localparam logic [4:0] DIV_LAST  = 5'(DIV_LAT - 2);

    typedef logic [WIDTH-1:0] word_t;

    state_e     state_reg, state_next;
    logic [4:0] cnt_reg, last_cnt;
    logic       qm1_reg, negq_reg, ovf_reg, dz_reg, mult_reg, exc_reg, rdy_reg;
    word_t      acc_reg, lo_reg, m_reg, result_reg;

    logic       start_mult, start_div, div_zero;
    word_t      neg_a, neg_b, neg_q, abs_a, abs_b;
    logic       nega_cout, negb_cout, negq_cout, unused_carries;

    booth_op_e  booth_op;
    word_t      add_a, add_b, add_sum;
    logic       add_sub, add_cout, div_ok;
    logic [1:0] add_hi_b, ext_hi;

    assign start_mult = bus.ctrl_MULT & ~bus.ctrl_DIV;
    assign start_div  = bus.ctrl_DIV & ~bus.ctrl_MULT;

    cla_addsub32 u_neg_a (.a({WIDTH{1'b0}}), .b(bus.data_operandA), .sub(1'b1), .sum(neg_a), .cout(nega_cout));
    cla_addsub32 u_neg_b (.a({WIDTH{1'b0}}), .b(bus.data_operandB), .sub(1'b1), .sum(neg_b), .cout(negb_cout));
    cla_addsub32 u_neg_q (.a({WIDTH{1'b0}}), .b(lo_reg),            .sub(1'b1), .sum(neg_q), .cout(negq_cout));
    cla_addsub32 u_step  (.a(add_a),         .b(add_b),             .sub(add_sub), .sum(add_sum), .cout(add_cout));

    // 0 - B carries out only when B is zero.
    assign div_zero       = start_div & negb_cout;
    assign abs_a          = bus.data_operandA[WIDTH-1] ? neg_a : bus.data_operandA;
    assign abs_b          = bus.data_operandB[WIDTH-1] ? neg_b : bus.data_operandB;
    assign unused_carries = nega_cout ^ negq_cout;

    booth_recode4 u_booth (.bits({lo_reg[1:0], qm1_reg}), .op(booth_op));

    always_comb begin
        add_a    = acc_reg;
        add_b    = '0;
        add_sub  = 1'b0;
        add_hi_b = 2'b00;
        if (state_reg == DIV) begin
            add_a   = {acc_reg[WIDTH-2:0], lo_reg[WIDTH-1]};
            add_b   = m_reg;
            add_sub = 1'b1;
        end else begin
            case (booth_op)
                ADD_M:   add_b = m_reg;
                ADD_2M:  add_b = {m_reg[WIDTH-2:0], 1'b0};
                SUB_M:   begin add_b = m_reg;                    add_sub = 1'b1; end
                SUB_2M:  begin add_b = {m_reg[WIDTH-2:0], 1'b0}; add_sub = 1'b1; end
                default: add_b = '0;
            endcase
            if (booth_op != ZERO) add_hi_b = {2{m_reg[WIDTH-1]}};
        end
    end

    // Two guard bits above P_hi absorb +-2M before the arithmetic shift by 2.
    assign ext_hi   = {2{acc_reg[WIDTH-1]}} + (add_sub ? ~add_hi_b : add_hi_b) + {1'b0, add_cout};
    assign div_ok   = acc_reg[WIDTH-1] | add_cout;
    assign last_cnt = (state_reg == MULT) ? MULT_LAST : DIV_LAST;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_reg <= IDLE;
        else          state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        if (start_mult) begin
            state_next = MULT;
        end else if (start_div) begin
            state_next = div_zero ? DONE : DIV;
        end else begin
            case (state_reg)
                MULT, DIV: if (cnt_reg == last_cnt) state_next = DONE;
                DONE:      state_next = IDLE;
                default:   state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_reg <= '0; acc_reg <= '0; lo_reg <= '0; m_reg <= '0;
            qm1_reg <= 1'b0; negq_reg <= 1'b0; ovf_reg <= 1'b0; dz_reg <= 1'b0;
            mult_reg <= 1'b0; result_reg <= '0; exc_reg <= 1'b0; rdy_reg <= 1'b0;
        end else begin
            rdy_reg <= 1'b0;
            if (start_mult || start_div) begin
                cnt_reg  <= '0;
                acc_reg  <= '0;
                qm1_reg  <= 1'b0;
                mult_reg <= start_mult;
                dz_reg   <= div_zero;
                lo_reg   <= start_mult ? bus.data_operandB : abs_a;
                m_reg    <= start_mult ? bus.data_operandA : abs_b;
                negq_reg <= bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
                ovf_reg  <= (bus.data_operandA == {1'b1, {(WIDTH-1){1'b0}}}) && (&bus.data_operandB);
            end else begin
                case (state_reg)
                    MULT: begin
                        acc_reg <= {ext_hi, add_sum[WIDTH-1:2]};
                        lo_reg  <= {add_sum[1:0], lo_reg[WIDTH-1:2]};
                        qm1_reg <= lo_reg[1];
                        if (cnt_reg != last_cnt) cnt_reg <= cnt_reg + 5'd1;
                    end
                    DIV: begin
                        acc_reg <= div_ok ? add_sum : add_a;
                        lo_reg  <= {lo_reg[WIDTH-2:0], div_ok};
                        if (cnt_reg != last_cnt) cnt_reg <= cnt_reg + 5'd1;
                    end
                    DONE: begin
                        rdy_reg <= 1'b1;
                        if (dz_reg) begin
                            result_reg <= '0;
                            exc_reg    <= 1'b1;
                        end else if (mult_reg) begin
                            result_reg <= lo_reg;
                            exc_reg    <= (acc_reg != {WIDTH{lo_reg[WIDTH-1]}});
                        end else begin
                            result_reg <= negq_reg ? neg_q : lo_reg;
                            exc_reg    <= ovf_reg;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.data_result    = result_reg;
    assign bus.data_exception = exc_reg;
    assign bus.data_resultRDY = rdy_reg;
    assign bus.busy           = (state_reg != IDLE);
endmodule

// File: tb/tb_multdiv_iter.sv
// Directed and random checks of multdiv_iter against a plain-arithmetic reference.
module tb_multdiv_iter;
    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    int   checks  = 0;
    int   passes  = 0;

    multdiv_if bus ();

    multdiv_iter dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    function automatic void model(input logic is_mult, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic e, output int lat);
        longint      prod;
        logic [63:0] pbits;
        if (is_mult) begin
            prod  = longint'($signed(a)) * longint'($signed(b));
            pbits = prod;
            r     = pbits[31:0];
            e     = (pbits[63:32] != {32{pbits[31]}});
            lat   = 17;
        end else if (b == 32'd0) begin
            r = 32'd0; e = 1'b1; lat = 1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            r = 32'h8000_0000; e = 1'b1; lat = 33;
        end else begin
            r = 32'($signed(a) / $signed(b)); e = 1'b0; lat = 33;
        end
    endfunction

    // Called at a negedge; returns at the negedge just after the start edge.
    task automatic start_op(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
        bus.ctrl_MULT     = m;
        bus.ctrl_DIV      = d;
        bus.data_operandA = a;
        bus.data_operandB = b;
        @(negedge clock);
        bus.ctrl_MULT     = 1'b0;
        bus.ctrl_DIV      = 1'b0;
        bus.data_operandA = $urandom;
        bus.data_operandB = $urandom;
    endtask

    task automatic wait_rdy(input int budget, output int lat);
        lat = -1;
        for (int k = 1; k <= budget; k++) begin
            @(negedge clock);
            if (bus.data_resultRDY === 1'b1) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic run_op(input string tag, input logic m, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] er;
        logic        ee;
        int          el;
        int          lat;
        model(m, a, b, er, ee, el);
        start_op(m, !m, a, b);
        check({tag, "_busy"}, 32'(bus.busy), 32'd1);
        wait_rdy(40, lat);
        $display("op %s %s A=0x%08h B=0x%08h result=0x%08h exc=%0b lat=%0d", tag, m ? "MUL" : "DIV",
                 a, b, bus.data_result, bus.data_exception, lat);
        check({tag, "_lat"}, 32'(lat), 32'(el));
        check({tag, "_result"}, bus.data_result, er);
        check({tag, "_exc"}, 32'(bus.data_exception), 32'(ee));
        @(negedge clock);
        check({tag, "_rdy_pulse"}, 32'(bus.data_resultRDY), 32'd0);
        check({tag, "_idle"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        logic [31:0] er;
        logic        ee;
        int          el;
        int          lat;

        bus.ctrl_MULT = 1'b0; bus.ctrl_DIV = 1'b0;
        bus.data_operandA = '0; bus.data_operandB = '0;
        repeat (3) @(negedge clock);
        check("rst_result", bus.data_result, 32'd0);
        check("rst_exc", 32'(bus.data_exception), 32'd0);
        check("rst_rdy", 32'(bus.data_resultRDY), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        reset_n = 1'b1;
        @(negedge clock);

        run_op("mul_7x-3", 1'b1, 32'd7, 32'hFFFF_FFFD);
        run_op("mul_ovf", 1'b1, 32'h0001_0000, 32'h0001_0000);
        run_op("mul_min", 1'b1, 32'h8000_0000, 32'd1);
        run_op("div_-7/2", 1'b0, 32'hFFFF_FFF9, 32'd2);
        run_op("div_100/-7", 1'b0, 32'd100, 32'hFFFF_FFF9);
        run_op("div_by0", 1'b0, 32'd5, 32'd0);
        run_op("div_min/-1", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF);

        // Reset in the middle of a multiply.
        start_op(1'b1, 1'b0, 32'd123, 32'd456);
        wait_rdy(7, lat);
        check("rst_mid_no_early", 32'(lat), 32'hFFFF_FFFF);
        @(posedge clock);
        #1 reset_n = 1'b0;
        #1;
        check("rst_mid_result", bus.data_result, 32'd0);
        check("rst_mid_exc", 32'(bus.data_exception), 32'd0);
        check("rst_mid_rdy", 32'(bus.data_resultRDY), 32'd0);
        check("rst_mid_busy", 32'(bus.busy), 32'd0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        wait_rdy(25, lat);
        check("rst_mid_no_rdy", 32'(lat), 32'hFFFF_FFFF);
        run_op("div_9/3", 1'b0, 32'd9, 32'd3);

        // Restart a divide with a multiply at edge 10.
        start_op(1'b0, 1'b1, 32'd9, 32'd3);
        wait_rdy(9, lat);
        check("restart_no_div_rdy", 32'(lat), 32'hFFFF_FFFF);
        model(1'b1, 32'd4, 32'd5, er, ee, el);
        start_op(1'b1, 1'b0, 32'd4, 32'd5);
        check("restart_busy", 32'(bus.busy), 32'd1);
        wait_rdy(40, lat);
        $display("op restart MUL A=0x00000004 B=0x00000005 result=0x%08h exc=%0b lat=%0d",
                 bus.data_result, bus.data_exception, lat);
        check("restart_lat", 32'(lat), 32'(el));
        check("restart_result", bus.data_result, er);
        check("restart_exc", 32'(bus.data_exception), 32'(ee));
        @(negedge clock);

        // Both start lines together: ignored.
        start_op(1'b1, 1'b1, 32'd7, 32'd7);
        check("both_busy", 32'(bus.busy), 32'd0);
        wait_rdy(40, lat);
        $display("op both-high A=0x00000007 B=0x00000007 result=0x%08h lat=%0d", bus.data_result, lat);
        check("both_no_rdy", 32'(lat), 32'hFFFF_FFFF);
        check("both_result_held", bus.data_result, er);

        for (int i = 0; i < 24; i++) begin
            logic [31:0] ra, rb;
            logic        rm;
            int          sel;
            rm  = 1'($urandom_range(0, 1));
            ra  = $urandom;
            rb  = $urandom;
            sel = int'($urandom_range(0, 5));
            case (sel)
                0: rb = 32'd0;
                1: rb = 32'(int'($urandom_range(0, 20)) - 10);
                2: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                3: ra = {{16{ra[15]}}, ra[15:0]};
                default: ;
            endcase
            run_op($sformatf("rnd%0d", i), rm, ra, rb);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
